// File: rtl/robo_nav_if.sv
// Sensor/command bundle between the wall-following robot core and its map environment.
// master = environment (drives sensors), slave = robot core.
interface robo_nav_if #(
    parameter int W  = 5,
    parameter int CW = 8
);
    logic          habilita;
    logic          mao;
    logic          head;
    logic          lado;
    logic          avancar;
    logic          girar;
    logic          sentido;
    logic [W-1:0]  linha;
    logic [W-1:0]  coluna;
    logic [1:0]    orientacao;
    logic [CW-1:0] qtd_movimentos;
    logic          fim;
    logic          preso;

    modport master (
        output habilita, mao, head, lado,
        input  avancar, girar, sentido, linha, coluna, orientacao,
               qtd_movimentos, fim, preso
    );

    modport slave (
        input  habilita, mao, head, lado,
        output avancar, girar, sentido, linha, coluna, orientacao,
               qtd_movimentos, fim, preso
    );
endinterface

// File: rtl/robo_nav.sv
// Wall-following robot core: one advance or 90-degree rotation per enabled clock,
// tracking its own grid position/heading, halting on move budget or when boxed in.
module robo_nav #(
    parameter int         W       = 5,
    parameter int         ROWS    = 20,
    parameter int         COLS    = 20,
    parameter int         LIN0    = 1,
    parameter int         COL0    = 1,
    parameter logic [1:0] ORI0    = 2'b00,
    parameter int         CW      = 8,
    parameter int         MAX_MOV = 255
) (
    input  logic       clock,
    input  logic       reset,
    robo_nav_if.slave  bus
);
    localparam logic [1:0] HN = 2'b00;
    localparam logic [1:0] HS = 2'b01;
    localparam logic [1:0] HL = 2'b10;
    localparam logic [1:0] HO = 2'b11;

    typedef enum logic [1:0] {PROCURA, SEGUE, CURVA} state_t;

    state_t        state_p1;
    logic          mao_p1;
    logic          adv_p1;
    logic          gir_p1;
    logic          sen_p1;
    logic [W-1:0]  lin_p1;
    logic [W-1:0]  col_p1;
    logic [1:0]    ori_p1;
    logic [CW-1:0] cnt_p1;
    logic [2:0]    turns_p1;
    logic          fim_p1;
    logic          preso_p1;

    logic          head_eff_p0;
    logic          lado_eff_p0;
    logic          do_adv_p0;
    logic          do_rot_p0;
    logic          rot_cw_p0;
    state_t        state_n_p0;
    logic [1:0]    side_h_p0;

    // cw=1 rotates clockwise (N->L->S->O), cw=0 counter-clockwise (N->O->S->L)
    function automatic logic [1:0] turn(input logic [1:0] h, input logic cw);
        logic [1:0] r;
        case (h)
            HN:      r = cw ? HL : HO;
            HS:      r = cw ? HO : HL;
            HL:      r = cw ? HS : HN;
            default: r = cw ? HN : HS;
        endcase
        return r;
    endfunction

    function automatic logic off_grid(input logic [1:0] h, input logic [W-1:0] r,
                                      input logic [W-1:0] c);
        logic e;
        case (h)
            HN:      e = (r == W'(1));
            HS:      e = (r == W'(ROWS));
            HL:      e = (c == W'(COLS));
            default: e = (c == W'(1));
        endcase
        return e;
    endfunction

    // ---- stage p0: effective sensors and action decision ----
    always_comb begin
        side_h_p0   = turn(ori_p1, mao_p1);
        head_eff_p0 = bus.head | off_grid(ori_p1, lin_p1, col_p1);
        lado_eff_p0 = bus.lado | off_grid(side_h_p0, lin_p1, col_p1);
    end

    always_comb begin
        do_adv_p0  = 1'b0;
        do_rot_p0  = 1'b0;
        rot_cw_p0  = ~mao_p1;
        state_n_p0 = state_p1;
        case (state_p1)
            PROCURA: begin
                if (lado_eff_p0 || head_eff_p0) state_n_p0 = SEGUE;
                if (!head_eff_p0) do_adv_p0 = 1'b1;
                else              do_rot_p0 = 1'b1;
            end
            SEGUE: begin
                if (!lado_eff_p0) begin
                    do_rot_p0  = 1'b1;
                    rot_cw_p0  = mao_p1;
                    state_n_p0 = CURVA;
                end else if (!head_eff_p0) begin
                    do_adv_p0 = 1'b1;
                end else begin
                    do_rot_p0 = 1'b1;
                end
            end
            CURVA: begin
                state_n_p0 = SEGUE;
                if (!head_eff_p0) do_adv_p0 = 1'b1;
                else              do_rot_p0 = 1'b1;
            end
            default: state_n_p0 = PROCURA;
        endcase
    end

    // ---- stage p1: registered action pulse and robot state ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p1 <= PROCURA;
            mao_p1   <= bus.mao;
            adv_p1   <= 1'b0;
            gir_p1   <= 1'b0;
            sen_p1   <= 1'b0;
            lin_p1   <= W'(LIN0);
            col_p1   <= W'(COL0);
            ori_p1   <= ORI0;
            cnt_p1   <= '0;
            turns_p1 <= '0;
            fim_p1   <= 1'b0;
            preso_p1 <= 1'b0;
        end else begin
            adv_p1 <= 1'b0;
            gir_p1 <= 1'b0;
            sen_p1 <= 1'b0;
            if (bus.habilita && !fim_p1 && !preso_p1) begin
                state_p1 <= state_n_p0;
                cnt_p1   <= cnt_p1 + CW'(1);
                if (cnt_p1 == CW'(MAX_MOV - 1)) fim_p1 <= 1'b1;
                if (do_adv_p0) begin
                    adv_p1   <= 1'b1;
                    turns_p1 <= '0;
                    case (ori_p1)
                        HN:      lin_p1 <= lin_p1 - W'(1);
                        HS:      lin_p1 <= lin_p1 + W'(1);
                        HL:      col_p1 <= col_p1 + W'(1);
                        default: col_p1 <= col_p1 - W'(1);
                    endcase
                end
                if (do_rot_p0) begin
                    gir_p1   <= 1'b1;
                    sen_p1   <= rot_cw_p0;
                    ori_p1   <= turn(ori_p1, rot_cw_p0);
                    turns_p1 <= turns_p1 + 3'd1;
                    // fourth consecutive rotation without advancing: no exit
                    if (turns_p1 == 3'd3) preso_p1 <= 1'b1;
                end
            end
        end
    end

    assign bus.avancar        = adv_p1;
    assign bus.girar          = gir_p1;
    assign bus.sentido        = sen_p1;
    assign bus.linha          = lin_p1;
    assign bus.coluna         = col_p1;
    assign bus.orientacao     = ori_p1;
    assign bus.qtd_movimentos = cnt_p1;
    assign bus.fim            = fim_p1;
    assign bus.preso          = preso_p1;
endmodule
